// File: rtl/db_arbiter.sv
// Two-master arbiter for the 32-bit memory data bus: fixed priority to M0 with
// an M1 anti-starvation limit, or round-robin when DBARB_RR_EN is defined.
`ifndef MEM_ACCESS_NONE
`define MEM_ACCESS_NONE 2'b00
`endif
`ifndef MEM_ACCESS_R
`define MEM_ACCESS_R 2'b01
`endif
`ifndef MEM_ACCESS_W
`define MEM_ACCESS_W 2'b10
`endif
`ifndef MEM_ACCESS_X
`define MEM_ACCESS_X 2'b11
`endif

module db_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        res,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_dataOut,
    input  logic [1:0]  m0_accessType,
    output logic        m0_ready,
    output logic [31:0] m0_dataIn,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_dataOut,
    input  logic [1:0]  m1_accessType,
    output logic        m1_ready,
    output logic [31:0] m1_dataIn,
    output logic [31:0] db_addr,
    output logic [31:0] db_dataOut,
    output logic [1:0]  db_accessType,
    input  logic        db_ready,
    input  logic [31:0] db_dataIn,
    output logic [1:0]  gnt
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t state, state_next;
    logic   req0, req1;
    logic   done0, done1;
    logic   m1_wins;

    assign req0  = (m0_accessType != `MEM_ACCESS_NONE);
    assign req1  = (m1_accessType != `MEM_ACCESS_NONE);
    assign done0 = (state == OWN0) && req0 && db_ready;
    assign done1 = (state == OWN1) && req1 && db_ready;

`ifdef DBARB_RR_EN
    // Tie-break looks at the post-completion owner so alternation is immediate.
    logic last, last_next;

    always_comb begin
        last_next = last;
        if (done0)
            last_next = 1'b0;
        else if (done1)
            last_next = 1'b1;
    end

    assign m1_wins = (last_next == 1'b0);

    always_ff @(posedge clk or negedge res) begin
        if (!res)
            last <= 1'b1;
        else
            last <= last_next;
    end
`else
    // Tie-break uses the updated count, so the Nth M0 completion hands over at once.
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt, cnt_next;

    always_comb begin
        cnt_next = starve_cnt;
        if (done1 || !req1)
            cnt_next = '0;
        else if (done0 && starve_cnt != LIMIT)
            cnt_next = starve_cnt + 1'b1;
    end

    assign m1_wins = (cnt_next == LIMIT);

    always_ff @(posedge clk or negedge res) begin
        if (!res)
            starve_cnt <= '0;
        else
            starve_cnt <= cnt_next;
    end
`endif

    always_ff @(posedge clk or negedge res) begin
        if (!res)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    state_next = m1_wins ? OWN1 : OWN0;
                else if (req0)
                    state_next = OWN0;
                else if (req1)
                    state_next = OWN1;
            end
            OWN0: begin
                if (!req0)
                    state_next = IDLE;
                else if (done0 && req1 && m1_wins)
                    state_next = OWN1;
            end
            OWN1: begin
                if (!req1)
                    state_next = IDLE;
                else if (done1 && req0 && !m1_wins)
                    state_next = OWN0;
            end
            default: state_next = IDLE;
        endcase
    end

    // Only the owner sees the slave; an idle bus is parked at all-zero.
    always_comb begin
        db_addr       = '0;
        db_dataOut    = '0;
        db_accessType = `MEM_ACCESS_NONE;
        m0_ready      = 1'b0;
        m1_ready      = 1'b0;
        case (state)
            OWN0: begin
                db_addr       = m0_addr;
                db_dataOut    = m0_dataOut;
                db_accessType = m0_accessType;
                m0_ready      = db_ready;
            end
            OWN1: begin
                db_addr       = m1_addr;
                db_dataOut    = m1_dataOut;
                db_accessType = m1_accessType;
                m1_ready      = db_ready;
            end
            default: ;
        endcase
    end

    assign gnt       = {state == OWN1, state == OWN0};
    assign m0_dataIn = db_dataIn;
    assign m1_dataIn = db_dataIn;

endmodule

// File: doc/db_arbiter.md
Name: db_arbiter

Overview:
- Two-master arbiter for the single 32-bit data bus in front of memory.
- Master 0 is the CPUCore data bus; master 1 is a DMA/debug port.
- A registered grant FSM selects one master, muxes it onto the slave bus, and routes the slave's `db_ready` back to the owner only.
- Fixed priority to M0 with an anti-starvation limit for M1; round-robin is optional.

Parameters:
- STARVE_LIMIT, 4: consecutive M0 completions allowed while M1 waits; minimum 1.
- CNT_W, 3: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  system clock, rising edge
- res  in  1  asynchronous, active-low reset
- m0_addr  in  32  M0 address
- m0_dataOut  in  32  M0 write data
- m0_accessType  in  2  M0 request; `MEM_ACCESS_R/W/X` = request, `MEM_ACCESS_NONE` = idle
- m0_ready  out  1  M0 transfer complete
- m0_dataIn  out  32  read data to M0
- m1_addr, m1_dataOut, m1_accessType, m1_ready, m1_dataIn  same as M0, for M1
- db_addr  out  32  slave address
- db_dataOut  out  32  slave write data
- db_accessType  out  2  slave access type
- db_ready  in  1  slave completion
- db_dataIn  in  32  slave read data
- gnt  out  2  registered one-hot owner; 00 = none

Behaviour:
- Reset (res=0, asynchronous, immediate):
  - state=IDLE, gnt=00, starve counter=0.
  - db_accessType=`MEM_ACCESS_NONE`, db_addr=0, db_dataOut=0.
  - m0_ready=m1_ready=0.
- Reset asserted mid-transfer aborts the transfer; no completion is reported to either master.
- States: IDLE, OWN0, OWN1; gnt mirrors state.
- Request: mK_accessType != `MEM_ACCESS_NONE`.
- IDLE: at posedge, any request moves to OWN0/OWN1 per policy. Arbitration latency is 1 cycle; the bus is driven from the next cycle.
- OWNk:
  - db_addr, db_dataOut, db_accessType = master k's inputs (combinational mux).
  - mk_ready = db_ready; the other master's ready = 0.
- Completion: posedge in OWNk with db_ready=1 and master k requesting. Re-arbitration happens at that same posedge, with no idle cycle between owners:
  - other master requesting and policy picks it -> switch;
  - else master k still requesting -> stay;
  - else -> IDLE.
- Master k drops its request before completion (protocol violation): return to IDLE at the next posedge. No ready is issued.
- Read data: db_dataIn is broadcast to m0_dataIn and m1_dataIn unmodified. Each master qualifies it with its own ready/protocol; slave read-data timing is passed through untouched.
- Fixed-priority policy (default):
  - Both requesting: M0 wins, unless counter == STARVE_LIMIT, in which case M1 wins.
  - Counter increments on each M0 completion while M1 is requesting (saturating at STARVE_LIMIT).
  - Counter clears on any M1 completion, or when M1 is not requesting.
- Simultaneous requests from IDLE follow the same rule.
- Ungranted master sees ready=0 and must hold its request stable until granted and completed.
- Slave outputs while IDLE: as at reset.

Optional Feature:
- Macro DBARB_RR_EN.
- Defined:
  - Starvation counter is not built.
  - A 1-bit `last` register records the most recent completing master (reset = M1, so M0 wins the first tie).
  - On a tie, the master other than `last` wins; strict alternation under continuous contention.
- Undefined: fixed priority with STARVE_LIMIT as above.

Test Plan:
- Single master:
  - M0 requests `MEM_ACCESS_R` addr 0x40, db_ready tied 1, M1 idle.
  - -> gnt=01 one cycle later; db_addr=0x40; m0_ready=1 on that cycle; m1_ready=0; IDLE after M0 drops.
- Simultaneous requests:
  - From IDLE: M0 W to 0x4C, M1 R from 0x44.
  - -> M0 served first; gnt switches 01->10 at the completion posedge with no idle cycle; M1 then gets db_addr=0x44.
- Starvation, STARVE_LIMIT=4:
  - M0 requests continuously, M1 requests continuously.
  - -> exactly 4 M0 completions, then one M1 completion, then M0 again; pattern repeats.
- Wait states:
  - db_ready held 0 for 3 cycles during M1 ownership while M0 requests.
  - -> gnt stays 10; db_* stable; m0_ready=0 throughout; switch only after db_ready=1.
- Reset mid-transfer:
  - res driven low between clock edges while in OWN1.
  - -> gnt=00 and db_accessType=`MEM_ACCESS_NONE` immediately, without a clock edge; after release, re-arbitration starts from IDLE.
- With DBARB_RR_EN defined:
  - Both masters requesting continuously, db_ready=1.
  - -> grants alternate 01,10,01,10…, starting with M0 after reset.
